// File: rtl/register_file_mp.sv
// Multi-port register file: byte-strobed dual write (B over A), N combinational
// read ports with optional same-cycle bypass, and a per-register busy scoreboard.
module register_file_mp #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned NUM_READ   = 2,
    parameter int unsigned ZERO_REG   = 1,
    parameter int unsigned BYPASS     = 1
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           we_a,
    input  logic [ADDR_WIDTH-1:0]          waddr_a,
    input  logic [DATA_WIDTH-1:0]          wdata_a,
    input  logic [DATA_WIDTH/8-1:0]        wstrb_a,
    input  logic                           we_b,
    input  logic [ADDR_WIDTH-1:0]          waddr_b,
    input  logic [DATA_WIDTH-1:0]          wdata_b,
    input  logic [DATA_WIDTH/8-1:0]        wstrb_b,
    input  logic [NUM_READ*ADDR_WIDTH-1:0] raddr,
    output logic [NUM_READ*DATA_WIDTH-1:0] rdata,
    output logic [NUM_READ-1:0]            rbusy,
    input  logic                           rsv_valid,
    input  logic [ADDR_WIDTH-1:0]          rsv_addr
);

    localparam int unsigned Depth    = 2 ** ADDR_WIDTH;
    localparam int unsigned NumBytes = DATA_WIDTH / 8;

    generate
        if ((NUM_READ < 1) || (NUM_READ > 4) || ((DATA_WIDTH % 8) != 0)) begin : gBadParams
            $error("register_file_mp: NUM_READ must be 1..4 and DATA_WIDTH a multiple of 8");
        end
    endgenerate

    logic [Depth-1:0][DATA_WIDTH-1:0] regs;
    logic [Depth-1:0]                 busy;
    logic [Depth-1:0]                 busyNext;
    logic                             wrEnA;
    logic                             wrEnB;

    // Data writes to the hardwired zero register are dropped entirely
    assign wrEnA = we_a && !((ZERO_REG != 0) && (waddr_a == '0));
    assign wrEnB = we_b && !((ZERO_REG != 0) && (waddr_b == '0));

    // Any enabled write retires the pending producer; a new reserve wins over it
    always_comb begin
        busyNext = busy;
        for (int unsigned r = 0; r < Depth; r++) begin
            if ((we_a && (waddr_a == ADDR_WIDTH'(r))) || (we_b && (waddr_b == ADDR_WIDTH'(r)))) begin
                busyNext[r] = 1'b0;
            end
            if (rsv_valid && (rsv_addr == ADDR_WIDTH'(r))) begin
                busyNext[r] = 1'b1;
            end
        end
        if (ZERO_REG != 0) begin
            busyNext[0] = 1'b0;
        end
    end

    // Port B is applied after port A so it wins any byte both enable
    always_ff @(posedge clk) begin
        if (reset) begin
            regs <= '0;
            busy <= '0;
        end else begin
            for (int unsigned k = 0; k < NumBytes; k++) begin
                if (wrEnA && wstrb_a[k]) begin
                    regs[waddr_a][8*k +: 8] <= wdata_a[8*k +: 8];
                end
                if (wrEnB && wstrb_b[k]) begin
                    regs[waddr_b][8*k +: 8] <= wdata_b[8*k +: 8];
                end
            end
            busy <= busyNext;
        end
    end

    for (genvar p = 0; p < NUM_READ; p++) begin : gRead
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] val;

        assign addr = raddr[p*ADDR_WIDTH +: ADDR_WIDTH];

        // Stored value, optionally overlaid with the bytes landing this cycle
        always_comb begin
            val = regs[addr];
            if (BYPASS != 0) begin
                for (int unsigned k = 0; k < NumBytes; k++) begin
                    if (wrEnA && (waddr_a == addr) && wstrb_a[k]) begin
                        val[8*k +: 8] = wdata_a[8*k +: 8];
                    end
                    if (wrEnB && (waddr_b == addr) && wstrb_b[k]) begin
                        val[8*k +: 8] = wdata_b[8*k +: 8];
                    end
                end
            end
            if ((ZERO_REG != 0) && (addr == '0)) begin
                val = '0;
            end
        end

        assign rdata[p*DATA_WIDTH +: DATA_WIDTH] = val;
        assign rbusy[p]                          = busy[addr];
    end

endmodule

// File: tb/tb_register_file_mp.sv
// Bench for register_file_mp: two instances (zero-reg+bypass, plain) against a
// byte-level reference model, plus directed literal expectations.
module tb_register_file_mp;

    localparam int unsigned DW    = 32;
    localparam int unsigned AW    = 5;
    localparam int unsigned NR    = 2;
    localparam int unsigned NB    = DW / 8;
    localparam int unsigned DEPTH = 32;

    logic            clk = 1'b0;
    logic            reset;
    logic            we_a, we_b, rsv_valid;
    logic [AW-1:0]   waddr_a, waddr_b, rsv_addr;
    logic [DW-1:0]   wdata_a, wdata_b;
    logic [NB-1:0]   wstrb_a, wstrb_b;
    logic [NR*AW-1:0] raddr;
    logic [NR*DW-1:0] rdata0, rdata1;
    logic [NR-1:0]   rbusy0, rbusy1;

    int checks   = 0;
    int failures = 0;

    // Model state: index 0 = ZERO_REG=1/BYPASS=1 instance, 1 = ZERO_REG=0/BYPASS=0
    logic [DW-1:0] mem   [2][DEPTH];
    bit            busyM [2][DEPTH];
    bit            modelValid = 1'b0;

    register_file_mp #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_READ(NR), .ZERO_REG(1), .BYPASS(1)) dut0 (
        .clk(clk), .reset(reset),
        .we_a(we_a), .waddr_a(waddr_a), .wdata_a(wdata_a), .wstrb_a(wstrb_a),
        .we_b(we_b), .waddr_b(waddr_b), .wdata_b(wdata_b), .wstrb_b(wstrb_b),
        .raddr(raddr), .rdata(rdata0), .rbusy(rbusy0),
        .rsv_valid(rsv_valid), .rsv_addr(rsv_addr)
    );

    register_file_mp #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_READ(NR), .ZERO_REG(0), .BYPASS(0)) dut1 (
        .clk(clk), .reset(reset),
        .we_a(we_a), .waddr_a(waddr_a), .wdata_a(wdata_a), .wstrb_a(wstrb_a),
        .we_b(we_b), .waddr_b(waddr_b), .wdata_b(wdata_b), .wstrb_b(wstrb_b),
        .raddr(raddr), .rdata(rdata1), .rbusy(rbusy1),
        .rsv_valid(rsv_valid), .rsv_addr(rsv_addr)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", name, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] gotData(input int cfg, input int p);
        return (cfg == 0) ? rdata0[p*DW +: DW] : rdata1[p*DW +: DW];
    endfunction

    function automatic logic gotBusy(input int cfg, input int p);
        return (cfg == 0) ? rbusy0[p] : rbusy1[p];
    endfunction

    // Expected read: stored value, plus same-cycle bytes (B over A) when bypassing
    function automatic logic [DW-1:0] expRead(input int cfg, input logic [AW-1:0] a);
        logic [DW-1:0] v;
        v = mem[cfg][a];
        if (cfg == 0) begin
            if (a == '0) return '0;
            for (int k = 0; k < int'(NB); k++) begin
                if (we_b && (waddr_b == a) && wstrb_b[k])
                    v[8*k +: 8] = wdata_b[8*k +: 8];
                else if (we_a && (waddr_a == a) && wstrb_a[k])
                    v[8*k +: 8] = wdata_a[8*k +: 8];
            end
        end
        return v;
    endfunction

    function automatic void modelStep(input int cfg);
        for (int r = 0; r < int'(DEPTH); r++) begin
            for (int k = 0; k < int'(NB); k++) begin
                if (we_b && (waddr_b == AW'(r)) && wstrb_b[k])
                    mem[cfg][r][8*k +: 8] = wdata_b[8*k +: 8];
                else if (we_a && (waddr_a == AW'(r)) && wstrb_a[k])
                    mem[cfg][r][8*k +: 8] = wdata_a[8*k +: 8];
            end
            if ((we_a && (waddr_a == AW'(r))) || (we_b && (waddr_b == AW'(r))))
                busyM[cfg][r] = 1'b0;
            if (rsv_valid && (rsv_addr == AW'(r)))
                busyM[cfg][r] = 1'b1;
            if ((cfg == 0) && (r == 0)) begin
                mem[cfg][r]   = '0;
                busyM[cfg][r] = 1'b0;
            end
        end
    endfunction

    // Compare every port of both instances each cycle, then advance the model
    always @(negedge clk) begin : compare
        logic [AW-1:0] a;
        if (modelValid && !reset) begin
            for (int cfg = 0; cfg < 2; cfg++) begin
                for (int p = 0; p < int'(NR); p++) begin
                    a = raddr[p*AW +: AW];
                    check($sformatf("model_rdata cfg%0d port%0d addr%0d", cfg, p, a),
                          gotData(cfg, p), expRead(cfg, a));
                    check($sformatf("model_rbusy cfg%0d port%0d addr%0d", cfg, p, a),
                          DW'(gotBusy(cfg, p)), DW'(busyM[cfg][a]));
                end
            end
        end
        if (reset) begin
            for (int cfg = 0; cfg < 2; cfg++) begin
                for (int r = 0; r < int'(DEPTH); r++) begin
                    mem[cfg][r]   = '0;
                    busyM[cfg][r] = 1'b0;
                end
            end
            modelValid = 1'b1;
        end else if (modelValid) begin
            modelStep(0);
            modelStep(1);
        end
    end

    task automatic idle();
        we_a = 1'b0; waddr_a = '0; wdata_a = '0; wstrb_a = '0;
        we_b = 1'b0; waddr_b = '0; wdata_b = '0; wstrb_b = '0;
        rsv_valid = 1'b0; rsv_addr = '0;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        raddr = {a1, a0};
    endtask

    task automatic wrA(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [NB-1:0] s);
        we_a = 1'b1; waddr_a = a; wdata_a = d; wstrb_a = s;
    endtask

    task automatic wrB(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [NB-1:0] s);
        we_b = 1'b1; waddr_b = a; wdata_b = d; wstrb_b = s;
    endtask

    task automatic rsv(input logic [AW-1:0] a);
        rsv_valid = 1'b1; rsv_addr = a;
    endtask

    initial begin
        reset = 1'b1;
        idle();
        raddr = '0;
        wrA(5'd5, 32'hDEADBEEF, 4'hF);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        idle();
        rd(5'd5, 5'd5);
        @(negedge clk);
        check("reset_drops_write cfg0", gotData(0, 0), 32'h0);
        check("reset_drops_write cfg1", gotData(1, 0), 32'h0);

        for (int a = 0; a < int'(DEPTH); a++) begin
            nextCycle();
            rd(AW'(a), AW'(31 - a));
            @(negedge clk);
            check($sformatf("reset_sweep cfg0 addr%0d", a), gotData(0, 0) | gotData(0, 1), 32'h0);
            check($sformatf("reset_sweep cfg1 addr%0d", a), gotData(1, 0) | gotData(1, 1), 32'h0);
            check($sformatf("reset_sweep busy addr%0d", a), DW'({rbusy0, rbusy1}), 32'h0);
        end

        nextCycle(); idle(); wrA(5'd3, 32'h11223344, 4'hF); rd(5'd3, 5'd0);
        @(negedge clk);
        check("bypass_same_cycle", gotData(0, 0), 32'h11223344);
        check("nobypass_same_cycle", gotData(1, 0), 32'h0);
        nextCycle(); idle(); rd(5'd3, 5'd0);
        @(negedge clk);
        check("write_after_edge cfg0", gotData(0, 0), 32'h11223344);
        check("write_after_edge cfg1", gotData(1, 0), 32'h11223344);

        nextCycle(); idle(); wrA(5'd7, 32'hAAAAAAAA, 4'hF); wrB(5'd7, 32'hBBBBBBBB, 4'h3); rd(5'd7, 5'd7);
        @(negedge clk);
        check("collision_bypass", gotData(0, 1), 32'hAAAABBBB);
        nextCycle(); idle(); rd(5'd7, 5'd7);
        @(negedge clk);
        check("collision cfg0", gotData(0, 0), 32'hAAAABBBB);
        check("collision cfg1", gotData(1, 1), 32'hAAAABBBB);

        nextCycle(); idle(); wrA(5'd9, 32'h12345678, 4'hF);
        nextCycle(); idle(); wrA(5'd9, 32'hFFFFFFFF, 4'h4); rd(5'd9, 5'd9);
        @(negedge clk);
        check("partial_preedge cfg1", gotData(1, 0), 32'h12345678);
        check("partial_bypass cfg0", gotData(0, 0), 32'h12FF5678);
        nextCycle(); idle(); rd(5'd9, 5'd9);
        @(negedge clk);
        check("partial cfg0", gotData(0, 1), 32'h12FF5678);
        check("partial cfg1", gotData(1, 1), 32'h12FF5678);

        nextCycle(); idle(); wrA(5'd0, 32'hCAFEF00D, 4'hF); rsv(5'd0); rd(5'd0, 5'd0);
        nextCycle(); idle(); rd(5'd0, 5'd0);
        @(negedge clk);
        check("zero_reg_data", gotData(0, 0), 32'h0);
        check("zero_reg_busy", DW'(rbusy0[0]), 32'h0);
        check("plain_reg0_data", gotData(1, 0), 32'hCAFEF00D);
        check("plain_reg0_busy", DW'(rbusy1[0]), 32'h1);

        nextCycle(); idle(); rsv(5'd4); rd(5'd4, 5'd4);
        @(negedge clk);
        check("busy_not_bypassed", DW'(rbusy0[0]), 32'h0);
        nextCycle(); idle(); wrB(5'd4, 32'hFFFFFFFF, 4'h0); rd(5'd4, 5'd4);
        @(negedge clk);
        check("reserve_sets_busy cfg0", DW'(rbusy0[0]), 32'h1);
        check("reserve_sets_busy cfg1", DW'(rbusy1[1]), 32'h1);
        nextCycle(); idle(); rd(5'd4, 5'd4);
        @(negedge clk);
        check("zero_strobe_clears_busy", DW'({rbusy0, rbusy1}), 32'h0);
        check("zero_strobe_keeps_data", gotData(0, 0) | gotData(1, 0), 32'h0);
        nextCycle(); idle(); wrA(5'd4, 32'h55667788, 4'hF); rsv(5'd4); rd(5'd4, 5'd4);
        nextCycle(); idle(); rd(5'd4, 5'd4);
        @(negedge clk);
        check("reserve_and_write_busy", DW'({rbusy0, rbusy1}), 32'hF);
        check("reserve_and_write_data cfg0", gotData(0, 0), 32'h55667788);
        check("reserve_and_write_data cfg1", gotData(1, 1), 32'h55667788);

        nextCycle(); idle(); wrA(5'd10, 32'h01020304, 4'h5); wrB(5'd11, 32'hA0B0C0D0, 4'hA); rd(5'd10, 5'd11);
        @(negedge clk);
        check("split_bypass_a", gotData(0, 0), 32'h00020004);
        check("split_bypass_b", gotData(0, 1), 32'hA000C000);
        nextCycle(); idle(); rd(5'd10, 5'd11);
        @(negedge clk);
        check("split_a cfg1", gotData(1, 0), 32'h00020004);
        check("split_b cfg1", gotData(1, 1), 32'hA000C000);

        // Mixed traffic over a small address window to force collisions
        for (int i = 0; i < 120; i++) begin
            nextCycle();
            reset     = ($urandom_range(0, 31) == 0);
            we_a      = 1'($urandom_range(0, 1));
            waddr_a   = AW'($urandom_range(0, 7));
            wdata_a   = DW'($urandom);
            wstrb_a   = NB'($urandom);
            we_b      = 1'($urandom_range(0, 1));
            waddr_b   = AW'($urandom_range(0, 7));
            wdata_b   = DW'($urandom);
            wstrb_b   = NB'($urandom);
            rsv_valid = 1'($urandom_range(0, 1));
            rsv_addr  = AW'($urandom_range(0, 7));
            rd(AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)));
        end
        nextCycle(); idle(); reset = 1'b0;
        @(negedge clk);
        nextCycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired before the bench completed");
        $fatal(1, "watchdog");
    end

endmodule
